// File: rtl/full_adder.sv
// Registered ripple-carry adder: WIDTH one-bit cells, 1-cycle latency, 1 op/cycle.
// Reset asserts asynchronously; its release is retimed so capture resumes one edge later.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic             rst_sync;
  logic             accept;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  // rst_sync stays low on the edge where rst_n is seen high for the first time,
  // so no datapath flop captures on that edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 1'b0;
    else        rst_sync <= 1'b1;
  end

  // Ripple chain: the carry variable walks from cell 0 to cell WIDTH-1.
  // NOTE: blocking (=) here is intentional; each cell must see the carry just
  // produced by the cell below it, and every output gets a default first so no latch forms.
  always_comb begin
    logic carry;
    sum_c = '0;
    carry = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout_c = carry;
  end

  assign accept = in_valid & rst_sync;

  // Operands are only looked at when accept is high, so X/Z on idle inputs never reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        sum  <= sum_c;
        cout <= cout_c;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH = 1, 8 and 32: directed corner cases plus randomized
// traffic checked against plain integer addition.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, c1, co1, ov1;
  logic [0:0] a1, b1, s1;
  logic       v8, c8, co8, ov8;
  logic [7:0] a8, b8, s8;
  logic        v32, c32, co32, ov32;
  logic [31:0] a32, b32, s32;

  int tests = 0;
  int fails = 0;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .out_valid(ov1));
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .cout(co8), .out_valid(ov8));
  full_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .a(a32), .b(b32), .cin(c32),
    .sum(s32), .cout(co32), .out_valid(ov32));

  task automatic idle_all();
    v1 = 1'b0; v8 = 1'b0; v32 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    a32 = '0; b32 = '0; c32 = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({co1, s1, ov1} !== 3'b000) begin
      fails++; $display("FAIL reset_w1 got=%b want=000", {co1, s1, ov1});
    end
    tests++;
    if ({co8, s8, ov8} !== 10'd0) begin
      fails++; $display("FAIL reset_w8 got=%h want=0", {co8, s8, ov8});
    end
    tests++;
    if ({co32, s32, ov32} !== 34'd0) begin
      fails++; $display("FAIL reset_w32 got=%h want=0", {co32, s32, ov32});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_truth_table();
    logic [2:0] vec [8];
    logic [1:0] want [8];
    vec  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    want = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        tests++;
        if ({s1, co1, ov1} !== {want[k-1], 1'b1}) begin
          fails++;
          $display("FAIL truth_table[%0d] got sum,cout,valid=%b want=%b", k - 1,
                   {s1, co1, ov1}, {want[k-1], 1'b1});
        end
      end
      if (k < 8) begin
        v1 = 1'b1; a1 = vec[k][2]; b1 = vec[k][1]; c1 = vec[k][0];
      end else begin
        v1 = 1'b0;
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    tests++;
    if ({s1, co1, ov1} !== 3'b111) begin
      fails++; $display("FAIL hold_accept got=%b want=111", {s1, co1, ov1});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({s1, co1, ov1} !== 3'b110) begin
        fails++; $display("FAIL hold_cycle%0d got=%b want=110", k, {s1, co1, ov1});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] vec [3];
    logic [8:0]  want [3];
    vec  = '{{8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1}, {8'h12, 8'h34, 1'b1}};
    want = '{{1'b1, 8'h00}, {1'b1, 8'hFF}, {1'b0, 8'h47}};
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        tests++;
        if ({co8, s8, ov8} !== {want[k-1], 1'b1}) begin
          fails++;
          $display("FAIL b2b_w8[%0d] got cout=%b sum=%h valid=%b want cout=%b sum=%h valid=1",
                   k - 1, co8, s8, ov8, want[k-1][8], want[k-1][7:0]);
        end
      end
      if (k < 3) begin
        v8 = 1'b1; a8 = vec[k][16:9]; b8 = vec[k][8:1]; c8 = vec[k][0];
      end else begin
        v8 = 1'b0;
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; c32 = 1'b1;
    @(negedge clk);
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; c32 = 1'b1;
    tests++;
    if ({co32, s32} !== {1'b1, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL wrap_all_ones got cout=%b sum=%h want cout=1 sum=ffffffff", co32, s32);
    end
    @(negedge clk);
    v32 = 1'b0;
    tests++;
    if ({co32, s32, ov32} !== {1'b1, 32'h0, 1'b1}) begin
      fails++; $display("FAIL wrap_pow2 got cout=%b sum=%h valid=%b want cout=1 sum=0 valid=1",
                        co32, s32, ov32);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(negedge clk);
    tests++;
    if ({s1, co1} !== 2'b11) begin
      fails++; $display("FAIL mid_pre got=%b want=11", {s1, co1});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({s1, co1, ov1} !== 3'b000) begin
      fails++; $display("FAIL mid_reset got=%b want=000", {s1, co1, ov1});
    end
    @(posedge clk);
    #1;
    tests++;
    if ({s1, co1, ov1} !== 3'b000) begin
      fails++; $display("FAIL mid_reset_held got=%b want=000", {s1, co1, ov1});
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({s1, co1, ov1} !== 3'b000) begin
      fails++; $display("FAIL release_no_capture got=%b want=000", {s1, co1, ov1});
    end
    @(posedge clk);
    #1;
    tests++;
    if ({s1, co1, ov1} !== 3'b101) begin
      fails++; $display("FAIL release_first got=%b want=101", {s1, co1, ov1});
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_random();
    longint unsigned e_tot [3];
    logic            e_ov  [3];
    longint unsigned x, y;
    bit              c, v;
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e_tot[k] = 0; e_ov[k] = 1'b0;
    end
    for (int n = 0; n <= 3400; n++) begin
      if (n > 0) @(negedge clk);
      tests++;
      if ({co1, s1, ov1} !== {e_tot[0][1:0], e_ov[0]}) begin
        fails++; $display("FAIL rand_w1 cyc=%0d got=%b want=%b", n, {co1, s1, ov1},
                          {e_tot[0][1:0], e_ov[0]});
      end
      tests++;
      if ({co8, s8, ov8} !== {e_tot[1][8:0], e_ov[1]}) begin
        fails++; $display("FAIL rand_w8 cyc=%0d got=%h want=%h", n, {co8, s8, ov8},
                          {e_tot[1][8:0], e_ov[1]});
      end
      tests++;
      if ({co32, s32, ov32} !== {e_tot[2][32:0], e_ov[2]}) begin
        fails++; $display("FAIL rand_w32 cyc=%0d got=%h want=%h", n, {co32, s32, ov32},
                          {e_tot[2][32:0], e_ov[2]});
      end
      if (n == 3400) break;
      for (int k = 0; k < 3; k++) begin
        v = bit'($urandom_range(0, 1));
        c = bit'($urandom_range(0, 1));
        x = (($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF : longint'($urandom));
        y = (($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF : longint'($urandom));
        case (k)
          0: begin x &= 64'h1; y &= 64'h1; end
          1: begin x &= 64'hFF; y &= 64'hFF; end
          default: ;
        endcase
        e_ov[k] = v;
        if (v) e_tot[k] = x + y + longint'(c);
        case (k)
          0: begin
            v1 = v;
            if (v) begin a1 = x[0:0]; b1 = y[0:0]; c1 = c; end
            else   begin a1 = 'x; b1 = 'x; c1 = 1'bx; end
          end
          1: begin
            v8 = v;
            if (v) begin a8 = x[7:0]; b8 = y[7:0]; c8 = c; end
            else   begin a8 = 'x; b8 = 'x; c8 = 1'bx; end
          end
          default: begin
            v32 = v;
            if (v) begin a32 = x[31:0]; b32 = y[31:0]; c32 = c; end
            else   begin a32 = 'x; b32 = 'x; c32 = 1'bx; end
          end
        endcase
      end
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
